// File: rtl/bure_stage_interface_pkg.sv
// Shared types for the IF/EX-to-memory interface.
//   arb_owner_e : which requester owns a memory transaction (I-fetch or D load/store)
//   arb_state_e : arbiter request-phase state (IDLE = free to select, HOLD = payload locked)
//   owner_ptr_width() : pointer width helper for the owner FIFO
package bure_stage_interface_pkg;

    typedef enum logic {ARB_OWNER_I, ARB_OWNER_D} arb_owner_e;
    typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_e;

    // Width of a read/write pointer into a FIFO of the given power-of-two depth.
    function automatic int owner_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bure_owner_fifo.sv
// In-order FIFO of transaction owners. One entry is pushed per accepted memory
// request and popped per memory response, so the head is always the owner of
// the oldest outstanding transaction. Push and pop may happen in the same cycle.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (empties the FIFO)
//   push, push_owner  : enqueue an owner (ignored when full)
//   pop               : dequeue the head (ignored when empty)
//   head_owner        : owner at the head, valid when !empty
//   full, empty       : occupancy flags
module bure_owner_fifo
    import bure_stage_interface_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  arb_owner_e push_owner,
    input  logic       pop,
    output arb_owner_e head_owner,
    output logic       full,
    output logic       empty
);

    localparam int PW = owner_ptr_width(DEPTH);

    arb_owner_e       store_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full       = (count_reg == (PW+1)'(DEPTH));
    assign empty      = (count_reg == '0);
    assign push_ok    = push && !full;
    assign pop_ok     = pop && !empty;
    // Head is read combinationally: the response is routed in the cycle it arrives.
    assign head_owner = store_reg[rd_ptr_reg];

    // Storage needs no reset; only valid entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            store_reg[wr_ptr_reg] <= push_owner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (PW+1)'(1);
                2'b01:   count_reg <= count_reg - (PW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/bure_mem_arbiter.sv
// Shares the single external memory port between instruction fetch (I, read
// only) and load/store (D). D has fixed priority; I is promoted once it has been
// refused STARVE_LIMIT consecutive cycles. A request that the memory does not
// accept immediately is locked (HOLD) so the memory-side payload stays stable.
// Accepted owners are queued in order so each response is routed to its issuer.
// Ports:
//   i_clk, i_rstn            : clock, asynchronous active-low reset
//   i_i_*/o_i_*              : I-side request, grant, read response
//   i_d_*/o_d_*              : D-side request, grant, response (reads and writes)
//   o_mem_*/i_mem_*          : memory port (combinational request, in-order responses)
//   o_err_spurious           : sticky flag, response seen with no outstanding request
// Optional feature macro BURE_ARB_PERF_EN adds wrapping grant/stall counters
//   o_perf_i_grants, o_perf_d_grants, o_perf_stall_cycles.
module bure_mem_arbiter
    import bure_stage_interface_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_i_req,
    input  logic [ADDR_WIDTH-1:0]   i_i_addr,
    output logic                    o_i_gnt,
    output logic                    o_i_rvalid,
    output logic [DATA_WIDTH-1:0]   o_i_rdata,
    input  logic                    i_d_req,
    input  logic                    i_d_we,
    input  logic [ADDR_WIDTH-1:0]   i_d_addr,
    input  logic [DATA_WIDTH-1:0]   i_d_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_d_be,
    output logic                    o_d_gnt,
    output logic                    o_d_rvalid,
    output logic [DATA_WIDTH-1:0]   o_d_rdata,
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0] o_mem_be,
    input  logic                    i_mem_gnt,
    input  logic                    i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
    output logic                    o_err_spurious
`ifdef BURE_ARB_PERF_EN
    ,
    output logic [31:0]             o_perf_i_grants,
    output logic [31:0]             o_perf_d_grants,
    output logic [31:0]             o_perf_stall_cycles
`endif
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_W    = $clog2(STARVE_LIMIT + 1);

    arb_state_e         state_reg;
    arb_state_e         state_next;
    arb_owner_e         hold_owner_reg;
    arb_owner_e         sel_owner;
    arb_owner_e         head_owner;
    logic [CNT_W-1:0]   starve_cnt_reg;
    logic               err_reg;
    logic               fifo_full;
    logic               fifo_empty;
    logic               i_promoted;
    logic               mem_req;
    logic               accept;
    logic               i_gnt;
    logic               d_gnt;
    logic               resp_pop;

    assign i_promoted = i_i_req && (starve_cnt_reg == CNT_W'(STARVE_LIMIT));
    // A full FIFO blocks new requests even when a response frees a slot this cycle.
    assign mem_req    = (i_i_req || i_d_req) && !fifo_full;
    assign accept     = mem_req && i_mem_gnt;
    assign i_gnt      = accept && (sel_owner == ARB_OWNER_I);
    assign d_gnt      = accept && (sel_owner == ARB_OWNER_D);
    // A response with nothing outstanding is flagged, never routed.
    assign resp_pop   = i_mem_rvalid && !fifo_empty;

    // Selection and request-phase FSM.
    always_comb begin
        state_next = state_reg;
        sel_owner  = ARB_OWNER_I;
        if (state_reg == ARB_HOLD) begin
            sel_owner = hold_owner_reg;
            if (i_mem_gnt) begin
                state_next = ARB_IDLE;
            end
        end else begin
            sel_owner = (i_d_req && !i_promoted) ? ARB_OWNER_D : ARB_OWNER_I;
            if (mem_req && !i_mem_gnt) begin
                state_next = ARB_HOLD;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg      <= ARB_IDLE;
            hold_owner_reg <= ARB_OWNER_I;
        end else begin
            state_reg <= state_next;
            if (state_reg == ARB_IDLE && state_next == ARB_HOLD) begin
                hold_owner_reg <= sel_owner;
            end
        end
    end

    // Counts consecutive refused I cycles, saturating at the promotion threshold.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            starve_cnt_reg <= '0;
        end else if (i_i_req && !i_gnt) begin
            if (starve_cnt_reg != CNT_W'(STARVE_LIMIT)) begin
                starve_cnt_reg <= starve_cnt_reg + CNT_W'(1);
            end
        end else begin
            starve_cnt_reg <= '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            err_reg <= 1'b0;
        end else if (i_mem_rvalid && fifo_empty) begin
            err_reg <= 1'b1;
        end
    end

    bure_owner_fifo #(
        .DEPTH      (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk        (i_clk),
        .rst_n      (i_rstn),
        .push       (accept),
        .push_owner (sel_owner),
        .pop        (resp_pop),
        .head_owner (head_owner),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Combinational outputs are held at zero while reset is asserted.
    always_comb begin
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_be    = '0;
        o_i_gnt     = 1'b0;
        o_d_gnt     = 1'b0;
        o_i_rvalid  = 1'b0;
        o_d_rvalid  = 1'b0;
        o_i_rdata   = '0;
        o_d_rdata   = '0;
        if (i_rstn) begin
            o_mem_req = mem_req;
            o_i_gnt   = i_gnt;
            o_d_gnt   = d_gnt;
            if (sel_owner == ARB_OWNER_D) begin
                o_mem_we    = i_d_we;
                o_mem_addr  = i_d_addr;
                o_mem_wdata = i_d_wdata;
                o_mem_be    = i_d_be;
            end else begin
                o_mem_addr  = i_i_addr;
                o_mem_be    = {BE_WIDTH{1'b1}};
            end
            o_i_rvalid = resp_pop && (head_owner == ARB_OWNER_I);
            o_d_rvalid = resp_pop && (head_owner == ARB_OWNER_D);
            o_i_rdata  = i_mem_rdata;
            o_d_rdata  = i_mem_rdata;
        end
    end

    assign o_err_spurious = err_reg;

`ifdef BURE_ARB_PERF_EN
    logic [31:0] perf_i_reg;
    logic [31:0] perf_d_reg;
    logic [31:0] perf_stall_reg;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            perf_i_reg     <= '0;
            perf_d_reg     <= '0;
            perf_stall_reg <= '0;
        end else begin
            if (i_gnt) begin
                perf_i_reg <= perf_i_reg + 32'd1;
            end
            if (d_gnt) begin
                perf_d_reg <= perf_d_reg + 32'd1;
            end
            if ((i_i_req || i_d_req) && !accept) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end

    assign o_perf_i_grants     = perf_i_reg;
    assign o_perf_d_grants     = perf_d_reg;
    assign o_perf_stall_cycles = perf_stall_reg;
`endif

endmodule

// File: tb/tb_bure_mem_arbiter.sv
// Self-checking bench for bure_mem_arbiter: a vector table for the in-order
// routing / full-FIFO / spurious cases, hand sequences for starvation, HOLD and
// reset, then randomized traffic against a queue-based reference model.
module tb_bure_mem_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [BW-1:0] d_be;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          err_spurious;
`ifdef BURE_ARB_PERF_EN
    logic [31:0]   perf_i;
    logic [31:0]   perf_d;
    logic [31:0]   perf_stall;
`endif

    always #5 clk = ~clk;

    bure_mem_arbiter #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (DEPTH),
        .STARVE_LIMIT    (LIMIT)
    ) dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_i_req        (i_req),
        .i_i_addr       (i_addr),
        .o_i_gnt        (i_gnt),
        .o_i_rvalid     (i_rvalid),
        .o_i_rdata      (i_rdata),
        .i_d_req        (d_req),
        .i_d_we         (d_we),
        .i_d_addr       (d_addr),
        .i_d_wdata      (d_wdata),
        .i_d_be         (d_be),
        .o_d_gnt        (d_gnt),
        .o_d_rvalid     (d_rvalid),
        .o_d_rdata      (d_rdata),
        .o_mem_req      (mem_req),
        .o_mem_we       (mem_we),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .o_mem_be       (mem_be),
        .i_mem_gnt      (mem_gnt),
        .i_mem_rvalid   (mem_rvalid),
        .i_mem_rdata    (mem_rdata),
        .o_err_spurious (err_spurious)
`ifdef BURE_ARB_PERF_EN
        ,
        .o_perf_i_grants     (perf_i),
        .o_perf_d_grants     (perf_d),
        .o_perf_stall_cycles (perf_stall)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: owners of outstanding transactions (1 = D), refusal
    // streak of I, whether an unaccepted request is locked, sticky error.
    bit owner_q[$];
    int m_starve;
    bit m_locked;
    bit m_locked_owner;
    bit m_err;
    bit e_ig;
    bit e_dg;

    typedef struct {
        bit          ireq;
        bit          dreq;
        bit          mgnt;
        bit          rv;
        logic [31:0] rdata;
        bit          x_ig;
        bit          x_dg;
        bit          x_mreq;
        bit          x_irv;
        bit          x_drv;
        bit          x_err;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        owner_q.delete();
        m_starve       = 0;
        m_locked       = 1'b0;
        m_locked_owner = 1'b0;
        m_err          = 1'b0;
    endtask

    // Called just after a negedge with inputs already driven; checks outputs,
    // advances the model across the next posedge and returns at the next negedge.
    task automatic step(input string tag);
        bit full;
        bit sel;
        bit mreq;
        bit acc;
        bit pop;
        #1;
        full = (owner_q.size() >= DEPTH);
        mreq = (i_req || d_req) && !full;
        if (m_locked) sel = m_locked_owner;
        else          sel = d_req && !(i_req && m_starve == LIMIT);
        acc  = mreq && mem_gnt;
        pop  = mem_rvalid && (owner_q.size() > 0);
        e_ig = acc && !sel;
        e_dg = acc && sel;
        check({tag, ".mem_req"}, 64'(mem_req), 64'(mreq));
        check({tag, ".i_gnt"},   64'(i_gnt),   64'(e_ig));
        check({tag, ".d_gnt"},   64'(d_gnt),   64'(e_dg));
        if (mreq) begin
            check({tag, ".addr"},  64'(mem_addr),  sel ? 64'(d_addr) : 64'(i_addr));
            check({tag, ".we"},    64'(mem_we),    sel ? 64'(d_we) : 64'd0);
            check({tag, ".wdata"}, 64'(mem_wdata), sel ? 64'(d_wdata) : 64'd0);
            check({tag, ".be"},    64'(mem_be),    sel ? 64'(d_be) : 64'hF);
        end
        check({tag, ".i_rvalid"}, 64'(i_rvalid), 64'(pop && !owner_q[0]));
        check({tag, ".d_rvalid"}, 64'(d_rvalid), 64'(pop && owner_q[0]));
        if (pop) begin
            check({tag, ".rdata"}, owner_q[0] ? 64'(d_rdata) : 64'(i_rdata), 64'(mem_rdata));
        end
        check({tag, ".err"}, 64'(err_spurious), 64'(m_err));
        @(posedge clk);
        if (pop) void'(owner_q.pop_front());
        else if (mem_rvalid) m_err = 1'b1;
        if (acc) owner_q.push_back(sel);
        if (i_req && !e_ig) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
        else                m_starve = 0;
        if (!m_locked && mreq && !mem_gnt) begin
            m_locked       = 1'b1;
            m_locked_owner = sel;
        end else if (m_locked && mem_gnt) begin
            m_locked = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_req      = 1'b0;
        i_addr     = '0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
        d_be       = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    // While reset is low every output must read zero, even with requests and a response pending.
    task automatic check_reset_outputs(input string tag);
        check({tag, ".mem_req"},  64'(mem_req),      64'd0);
        check({tag, ".addr"},     64'(mem_addr),     64'd0);
        check({tag, ".be"},       64'(mem_be),       64'd0);
        check({tag, ".gnts"},     64'({i_gnt, d_gnt}), 64'd0);
        check({tag, ".rvalids"},  64'({i_rvalid, d_rvalid}), 64'd0);
        check({tag, ".rdata"},    64'({i_rdata, d_rdata}), 64'd0);
        check({tag, ".err"},      64'(err_spurious), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    initial begin
        bit i_busy;
        bit d_busy;
        model_clear();
        idle_inputs();
        rstn = 1'b1;
        // ireq dreq mgnt rv rdata  | ig dg mreq irv drv err
        tbl[0]  = '{1, 0, 1, 0, 32'h0, 1, 0, 1, 0, 0, 0};
        tbl[1]  = '{0, 1, 1, 0, 32'h0, 0, 1, 1, 0, 0, 0};
        tbl[2]  = '{0, 1, 1, 0, 32'h0, 0, 1, 1, 0, 0, 0};
        tbl[3]  = '{1, 0, 1, 0, 32'h0, 1, 0, 1, 0, 0, 0};
        tbl[4]  = '{0, 1, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 1, 1, 1, 32'hA, 0, 0, 0, 1, 0, 0};
        tbl[6]  = '{0, 1, 1, 1, 32'hB, 0, 1, 1, 0, 1, 0};
        tbl[7]  = '{0, 0, 1, 1, 32'hC, 0, 0, 0, 0, 1, 0};
        tbl[8]  = '{0, 0, 1, 1, 32'hD, 0, 0, 0, 1, 0, 0};
        tbl[9]  = '{0, 0, 1, 1, 32'hE, 0, 0, 0, 0, 1, 0};
        tbl[10] = '{0, 0, 1, 1, 32'hF, 0, 0, 0, 0, 0, 0};
        tbl[11] = '{0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 1};

        do_reset();

        // In-order routing, full-FIFO block, pop-then-accept, spurious response.
        i_addr = 32'h100;
        d_addr = 32'h200;
        d_be   = 4'hF;
        for (int k = 0; k < 12; k++) begin
            string t;
            t          = $sformatf("tbl%0d", k);
            i_req      = tbl[k].ireq;
            d_req      = tbl[k].dreq;
            mem_gnt    = tbl[k].mgnt;
            mem_rvalid = tbl[k].rv;
            mem_rdata  = tbl[k].rdata;
            #1;
            check({t, ".v_i_gnt"},    64'(i_gnt),        64'(tbl[k].x_ig));
            check({t, ".v_d_gnt"},    64'(d_gnt),        64'(tbl[k].x_dg));
            check({t, ".v_mem_req"},  64'(mem_req),      64'(tbl[k].x_mreq));
            check({t, ".v_i_rvalid"}, 64'(i_rvalid),     64'(tbl[k].x_irv));
            check({t, ".v_d_rvalid"}, 64'(d_rvalid),     64'(tbl[k].x_drv));
            check({t, ".v_err"},      64'(err_spurious), 64'(tbl[k].x_err));
            if (tbl[k].x_irv) check({t, ".v_i_rdata"}, 64'(i_rdata), 64'(tbl[k].rdata));
            if (tbl[k].x_drv) check({t, ".v_d_rdata"}, 64'(d_rdata), 64'(tbl[k].rdata));
            step(t);
        end
        idle_inputs();
        do_reset();

        // Starvation: both request continuously; I refused 8 times, wins the 9th, then D again.
        i_req   = 1'b1;
        i_addr  = 32'h1000;
        d_req   = 1'b1;
        d_addr  = 32'h2000;
        d_be    = 4'h3;
        mem_gnt = 1'b1;
        for (int k = 0; k < 10; k++) begin
            mem_rvalid = (owner_q.size() > 0);
            mem_rdata  = 32'(k);
            #1;
            check($sformatf("starve%0d.i_won", k), 64'(i_gnt), 64'(k == 8));
            check($sformatf("starve%0d.d_won", k), 64'(d_gnt), 64'(k != 8));
            step($sformatf("starve%0d", k));
        end
        idle_inputs();
        do_reset();

        // HOLD: memory stalls while D is selected; payload stays locked even after
        // I reaches the promotion threshold, D is granted first, then I.
        i_req   = 1'b1;
        i_addr  = 32'h4444;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h3C0;
        d_wdata = 32'h1234;
        d_be    = 4'h5;
        mem_gnt = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            check($sformatf("hold%0d.addr", k),  64'(mem_addr),  64'h3C0);
            check($sformatf("hold%0d.wdata", k), 64'(mem_wdata), 64'h1234);
            step($sformatf("hold%0d", k));
        end
        mem_gnt = 1'b1;
        #1;
        check("hold_release.d_gnt", 64'(d_gnt), 64'd1);
        step("hold_release");
        d_addr = 32'h3C4;
        #1;
        check("hold_after.i_gnt", 64'(i_gnt), 64'd1);
        step("hold_after");
        idle_inputs();
        do_reset();

        // Randomized traffic; requesters hold req and payload until granted.
        i_busy = 1'b0;
        d_busy = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!i_busy) begin
                i_req  = ($urandom_range(0, 2) != 0);
                i_addr = $urandom;
            end
            if (!d_busy) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = $urandom_range(0, 1);
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_be    = BW'($urandom);
            end
            mem_gnt    = ($urandom_range(0, 3) != 0);
            mem_rvalid = (owner_q.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_rdata  = $urandom;
            step($sformatf("rnd%0d", k));
            i_busy = i_req && !e_ig;
            d_busy = d_req && !e_dg;
        end
        idle_inputs();
        do_reset();

        // Reset mid-transaction discards outstanding entries.
        i_req   = 1'b1;
        i_addr  = 32'h80;
        d_req   = 1'b1;
        d_addr  = 32'h90;
        mem_gnt = 1'b1;
        step("mid0");
        step("mid1");
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD;
        rstn = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        idle_inputs();
        rstn = 1'b1;
        model_clear();
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h77;
        step("post_reset_spurious");
        mem_rvalid = 1'b0;
        step("post_reset_err");
        check("post_reset_err.flag", 64'(err_spurious), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
